// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART transmit arbiter slice:
//                FSM state encoding, default bit divider and frame length.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_START = 2'd1;
    localparam state_t ST_DATA  = 2'd2;
    localparam state_t ST_STOP  = 2'd3;

    // 50 MHz system clock / 9600 baud
    localparam int CLK_DIV_DEFAULT = 5208;

    // 8N1: one start bit, eight data bits, one stop bit
    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = FRAME_BITS - 2;

    // Width of the owner / pointer fields (up to 8 requesters)
    localparam int OWNER_W = 3;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter_if
//  Description : Requester-side bundle of the UART transmit arbiter.
//                master = requesters (drive req/data, observe status)
//                slave  = arbiter    (consume req/data, drive status/line)
//  Signals     : req     [NREQ]   - per-requester send request
//                data    [8*NREQ] - byte of requester i at [8i+7:8i]
//                ack     [NREQ]   - one-cycle capture pulse
//                busy             - frame on the line
//                owner   [3]      - requester of current/last frame
//                UART_TX          - serial line, idle high
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] data;
    logic [NREQ-1:0]   ack;
    logic              busy;
    logic [2:0]        owner;
    logic              UART_TX;

    modport master (
        output req,
        output data,
        input  ack,
        input  busy,
        input  owner,
        input  UART_TX
    );

    modport slave (
        input  req,
        input  data,
        output ack,
        output busy,
        output owner,
        output UART_TX
    );
endinterface : uart_tx_arbiter_if
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_bit_timer
//  Description : Divides sysclk down to UART bit periods. The counter runs
//                0..CLK_DIV-1 while run is high and is held at zero otherwise,
//                so the first bit after run rises lasts a full CLK_DIV cycles.
//  Ports       : sysclk   - system clock
//                reset    - synchronous active-high reset
//                run      - count enable; low clears the counter
//                bit_done - high on the last cycle of each bit period
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
    parameter int CLK_DIV = 5208
) (
    input  wire logic sysclk,
    input  wire logic reset,
    input  wire logic run,
    output logic      bit_done
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge sysclk) begin
        if (reset || !run) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last_cnt) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Decoded from the counter register; consumed only by the owning FSM
    assign bit_done = run && (r_cnt == c_last_cnt);

endmodule : uart_bit_timer
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Round-robin arbiter sharing one UART transmit line among
//                NREQ byte requesters, with an integrated 8N1 serializer.
//                Bit timing is derived from sysclk by uart_bit_timer.
//  Ports       : sysclk - system clock, rising edge
//                reset  - synchronous active-high reset
//                bus    - uart_tx_arbiter_if.slave (req/data in,
//                         ack/busy/owner/UART_TX out, all outputs registered)
//  Parameters  : NREQ    - number of requesters, 2..8
//                CLK_DIV - sysclk cycles per UART bit
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  wire logic          sysclk,
    input  wire logic          reset,
    uart_tx_arbiter_if.slave   bus
);

    localparam logic [2:0] c_last_bit = 3'(DATA_BITS - 1);
    localparam logic [2:0] c_last_req = 3'(NREQ - 1);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t               r_state;
    state_t               w_state_next;

    logic                 w_run;
    logic                 w_bit_done;

    logic [OWNER_W-1:0]   r_ptr;
    logic [OWNER_W-1:0]   w_ptr_d;
    logic [OWNER_W-1:0]   r_owner;
    logic [OWNER_W-1:0]   w_owner_d;
    logic [2:0]           r_bit_idx;
    logic [2:0]           w_bit_idx_d;
    logic [7:0]           r_shift;
    logic [7:0]           w_shift_d;
    logic [NREQ-1:0]      r_ack;
    logic [NREQ-1:0]      w_ack_d;
    logic                 r_busy;
    logic                 w_busy_d;
    logic                 r_tx;
    logic                 w_tx_d;

    logic                 w_rr_found;
    logic [OWNER_W-1:0]   w_winner;
    logic [3:0]           w_rr_idx;
    logic                 w_capture;

    // Zero-padded views so variable indexing never leaves the vector,
    // whatever NREQ is.
    logic [7:0]           w_req_pad;
    logic [63:0]          w_data_pad;

    assign w_req_pad  = 8'(bus.req);
    assign w_data_pad = 64'(bus.data);

    // ------------------------------------------------------------------
    // Bit timer: runs in every state except IDLE
    // ------------------------------------------------------------------
    assign w_run = (r_state != ST_IDLE);

    uart_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_timer (
        .sysclk   (sysclk),
        .reset    (reset),
        .run      (w_run),
        .bit_done (w_bit_done)
    );

    // ------------------------------------------------------------------
    // Round-robin search: walk upward from r_ptr, wrapping at NREQ, and
    // take the first set request. Evaluated every cycle; only used when
    // the FSM is idle.
    // ------------------------------------------------------------------
    always_comb begin
        w_rr_found = 1'b0;
        w_winner   = r_ptr;
        w_rr_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_rr_idx = {1'b0, r_ptr} + 4'(k);
            if (w_rr_idx >= 4'(NREQ)) begin
                w_rr_idx = w_rr_idx - 4'(NREQ);
            end
            if (!w_rr_found && w_req_pad[w_rr_idx[2:0]]) begin
                w_rr_found = 1'b1;
                w_winner   = w_rr_idx[2:0];
            end
        end
    end

    assign w_capture = (r_state == ST_IDLE) && w_rr_found;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rr_found) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_done) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_done && (r_bit_idx == c_last_bit)) begin
                    w_state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_bit_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / datapath next values. Every output is computed from
    // the next state so that the registered copy lines up with the state
    // it describes.
    // ------------------------------------------------------------------
    always_comb begin
        w_shift_d   = r_shift;
        w_bit_idx_d = r_bit_idx;
        w_ptr_d     = r_ptr;
        w_owner_d   = r_owner;
        w_ack_d     = '0;

        if (w_capture) begin
            w_shift_d   = w_data_pad[{w_winner, 3'b000} +: 8];
            w_ack_d     = {{(NREQ-1){1'b0}}, 1'b1} << w_winner;
            w_owner_d   = w_winner;
            w_ptr_d     = (w_winner == c_last_req) ? '0 : w_winner + 3'd1;
            w_bit_idx_d = '0;
        end else if ((r_state == ST_DATA) && w_bit_done) begin
            // LSB first: the bit on the line is always w_shift_d[0]
            w_shift_d   = {1'b0, r_shift[7:1]};
            w_bit_idx_d = r_bit_idx + 3'd1;
        end

        w_busy_d = (w_state_next != ST_IDLE);

        case (w_state_next)
            ST_START: w_tx_d = 1'b0;
            ST_DATA:  w_tx_d = w_shift_d[0];
            default:  w_tx_d = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath / output registers
    // ------------------------------------------------------------------
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_ack     <= '0;
            r_busy    <= 1'b0;
            r_tx      <= 1'b1;
        end else begin
            r_shift   <= w_shift_d;
            r_bit_idx <= w_bit_idx_d;
            r_ptr     <= w_ptr_d;
            r_owner   <= w_owner_d;
            r_ack     <= w_ack_d;
            r_busy    <= w_busy_d;
            r_tx      <= w_tx_d;
        end
    end

    assign bus.ack     = r_ack;
    assign bus.busy    = r_busy;
    assign bus.owner   = r_owner;
    assign bus.UART_TX = r_tx;

endmodule : uart_tx_arbiter
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Self-checking bench for uart_tx_arbiter. One instance with
//                a short divider exercises arbitration and framing, a second
//                with the default divider checks idle behaviour and timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int D    = 4;
    localparam int DB   = 5208;
    localparam int NR   = 2;
    localparam int TMAX = 512;

    logic sysclk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 sysclk = ~sysclk;

    uart_tx_arbiter_if #(.NREQ(NR)) ifa ();
    uart_tx_arbiter_if #(.NREQ(NR)) ifb ();

    uart_tx_arbiter #(.NREQ(NR), .CLK_DIV(D)) dut_a (
        .sysclk (sysclk),
        .reset  (rst_a),
        .bus    (ifa)
    );

    uart_tx_arbiter #(.NREQ(NR), .CLK_DIV(DB)) dut_b (
        .sysclk (sysclk),
        .reset  (rst_b),
        .bus    (ifb)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Requester byte queues (stimulus side) and reference-model bookkeeping
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         m_ptr;
    int         m_owner;
    int         grant_seq[$];

    // Observed and expected per-cycle traces
    logic       tr_tx   [TMAX];
    logic [1:0] tr_ack  [TMAX];
    logic       tr_busy [TMAX];
    logic [2:0] tr_own  [TMAX];
    logic       ex_tx   [TMAX];
    logic [1:0] ex_ack  [TMAX];
    logic       ex_busy [TMAX];
    logic [2:0] ex_own  [TMAX];

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    // Requesters hold req with the head byte until their queue drains
    task automatic drive_reqs();
        ifa.req[0]     = (q0.size() > 0);
        ifa.req[1]     = (q1.size() > 0);
        ifa.data[7:0]  = (q0.size() > 0) ? q0[0] : 8'h00;
        ifa.data[15:8] = (q1.size() > 0) ? q1[0] : 8'h00;
    endtask

    // Line level k cycles into an 8N1 frame carrying byte b
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        int bn;
        bn = k / D;
        if (bn == 0) return 1'b0;
        if (bn >= 9) return 1'b1;
        return b[bn-1];
    endfunction

    // Builds the expected traces from the queues (round robin, one frame of
    // 10*D cycles per grant, next grant one idle cycle later), then drives
    // the requesters for n cycles and records what the DUT did.
    task automatic run_scenario(input int n);
        logic [7:0] m0[$];
        logic [7:0] m1[$];
        logic [7:0] b;
        int e;
        int w;
        m0 = q0;
        m1 = q1;
        for (int j = 0; j < n; j++) begin
            ex_tx[j]   = 1'b1;
            ex_ack[j]  = 2'b00;
            ex_busy[j] = 1'b0;
            ex_own[j]  = 3'(m_owner);
        end
        e = 0;
        while (e < n && (m0.size() > 0 || m1.size() > 0)) begin
            if (m_ptr == 0) w = (m0.size() > 0) ? 0 : 1;
            else            w = (m1.size() > 0) ? 1 : 0;
            if (w == 0) b = m0.pop_front();
            else        b = m1.pop_front();
            for (int k = 0; k < 10*D; k++) begin
                if (e + k < n) begin
                    ex_tx[e+k]   = frame_bit(b, k);
                    ex_busy[e+k] = 1'b1;
                end
            end
            ex_ack[e] = (w == 0) ? 2'b01 : 2'b10;
            for (int j = e; j < n; j++) ex_own[j] = 3'(w);
            m_owner = w;
            m_ptr   = (w + 1) % NR;
            e       = e + 10*D + 1;
        end

        grant_seq.delete();
        drive_reqs();
        for (int j = 0; j < n; j++) begin
            tick();
            tr_tx[j]   = ifa.UART_TX;
            tr_ack[j]  = ifa.ack;
            tr_busy[j] = ifa.busy;
            tr_own[j]  = ifa.owner;
            if (ifa.ack[0] && q0.size() > 0) begin
                void'(q0.pop_front());
                grant_seq.push_back(0);
            end
            if (ifa.ack[1] && q1.size() > 0) begin
                void'(q1.pop_front());
                grant_seq.push_back(1);
            end
            drive_reqs();
        end
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        tick();
        tick();
        rst_a   = 1'b0;
        m_ptr   = 0;
        m_owner = 0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.req = '0; ifa.data = '0;
        ifb.req = '0; ifb.data = '0;
        tick(); tick(); tick();
        n_checks++;
        if ({ifa.UART_TX, ifa.busy, ifa.ack, ifa.owner} !== 7'b1_0_00_000) begin
            n_errors++;
            $display("FAIL reset_a: tx/busy/ack/owner got %b/%b/%b/%0d expected 1/0/00/0",
                     ifa.UART_TX, ifa.busy, ifa.ack, ifa.owner);
        end
        n_checks++;
        if ({ifb.UART_TX, ifb.busy, ifb.ack, ifb.owner} !== 7'b1_0_00_000) begin
            n_errors++;
            $display("FAIL reset_b: tx/busy/ack/owner got %b/%b/%b/%0d expected 1/0/00/0",
                     ifb.UART_TX, ifb.busy, ifb.ack, ifb.owner);
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        m_ptr   = 0;
        m_owner = 0;
        tick();
    endtask

    task automatic test_single();
        int acks;
        q0 = '{8'h4A};
        q1.delete();
        run_scenario(45);
        acks = 0;
        for (int j = 0; j < 45; j++) begin
            n_checks++;
            if ({tr_tx[j], tr_ack[j], tr_busy[j], tr_own[j]} !==
                {ex_tx[j], ex_ack[j], ex_busy[j], ex_own[j]}) begin
                n_errors++;
                $display("FAIL single cyc %0d: tx/ack/busy/owner got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                         j, tr_tx[j], tr_ack[j], tr_busy[j], tr_own[j],
                         ex_tx[j], ex_ack[j], ex_busy[j], ex_own[j]);
            end
            if (tr_ack[j] != 2'b00) acks++;
        end
        n_checks++;
        if (acks !== 1) begin
            n_errors++;
            $display("FAIL single ack_count: got %0d expected 1", acks);
        end
    endtask

    task automatic test_simultaneous();
        int a0;
        int a1;
        reset_a();
        q0 = '{8'h4A};
        q1 = '{8'h19};
        run_scenario(90);
        a0 = -1;
        a1 = -1;
        for (int j = 0; j < 90; j++) begin
            n_checks++;
            if ({tr_tx[j], tr_ack[j], tr_busy[j], tr_own[j]} !==
                {ex_tx[j], ex_ack[j], ex_busy[j], ex_own[j]}) begin
                n_errors++;
                $display("FAIL simul cyc %0d: tx/ack/busy/owner got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                         j, tr_tx[j], tr_ack[j], tr_busy[j], tr_own[j],
                         ex_tx[j], ex_ack[j], ex_busy[j], ex_own[j]);
            end
            if (tr_ack[j][0] && a0 < 0) a0 = j;
            if (tr_ack[j][1] && a1 < 0) a1 = j;
        end
        n_checks++;
        if (a0 !== 0 || (a1 - a0) !== 41) begin
            n_errors++;
            $display("FAIL simul spacing: ack0 at %0d ack1 at %0d expected 0 and 41", a0, a1);
        end
    endtask

    task automatic test_fairness();
        int ptr0;
        int n;
        ptr0 = m_ptr;
        q0.delete();
        q1.delete();
        for (int i = 0; i < 3; i++) begin
            q0.push_back(8'($urandom_range(0, 255)));
            q1.push_back(8'($urandom_range(0, 255)));
        end
        n = 6 * 41 + 2;
        run_scenario(n);
        for (int j = 0; j < n; j++) begin
            n_checks++;
            if ({tr_tx[j], tr_ack[j], tr_busy[j], tr_own[j]} !==
                {ex_tx[j], ex_ack[j], ex_busy[j], ex_own[j]}) begin
                n_errors++;
                $display("FAIL fair cyc %0d: tx/ack/busy/owner got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                         j, tr_tx[j], tr_ack[j], tr_busy[j], tr_own[j],
                         ex_tx[j], ex_ack[j], ex_busy[j], ex_own[j]);
            end
        end
        n_checks++;
        if (grant_seq.size() !== 6) begin
            n_errors++;
            $display("FAIL fair grant_count: got %0d expected 6", grant_seq.size());
        end
        for (int i = 0; i < grant_seq.size(); i++) begin
            n_checks++;
            if (grant_seq[i] !== (ptr0 + i) % NR) begin
                n_errors++;
                $display("FAIL fair grant[%0d]: got %0d expected %0d", i, grant_seq[i], (ptr0 + i) % NR);
            end
        end
    endtask

    task automatic test_random();
        int n0;
        int n1;
        int n;
        for (int it = 0; it < 4; it++) begin
            n0 = $urandom_range(0, 2);
            n1 = $urandom_range(0, 2);
            if (n0 == 0 && n1 == 0) n0 = 1;
            q0.delete();
            q1.delete();
            for (int i = 0; i < n0; i++) q0.push_back(8'($urandom_range(0, 255)));
            for (int i = 0; i < n1; i++) q1.push_back(8'($urandom_range(0, 255)));
            n = (n0 + n1) * 41 + 2;
            run_scenario(n);
            for (int j = 0; j < n; j++) begin
                n_checks++;
                if ({tr_tx[j], tr_ack[j], tr_busy[j], tr_own[j]} !==
                    {ex_tx[j], ex_ack[j], ex_busy[j], ex_own[j]}) begin
                    n_errors++;
                    $display("FAIL random it%0d cyc %0d: tx/ack/busy/owner got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                             it, j, tr_tx[j], tr_ack[j], tr_busy[j], tr_own[j],
                             ex_tx[j], ex_ack[j], ex_busy[j], ex_own[j]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        int n;
        b  = 8'($urandom_range(0, 255));
        q0 = '{b};
        q1.delete();
        drive_reqs();
        // Samples 16..19 are DATA bit 3 with D=4; reset is applied at 18
        for (int j = 0; j < 18; j++) begin
            tick();
            n_checks++;
            if (ifa.UART_TX !== frame_bit(b, j)) begin
                n_errors++;
                $display("FAIL midrst line cyc %0d: got %b expected %b", j, ifa.UART_TX, frame_bit(b, j));
            end
            if (ifa.ack[0] && q0.size() > 0) void'(q0.pop_front());
            drive_reqs();
        end
        rst_a = 1'b1;
        tick();
        n_checks++;
        if ({ifa.UART_TX, ifa.busy, ifa.ack, ifa.owner} !== 7'b1_0_00_000) begin
            n_errors++;
            $display("FAIL midrst after_reset: tx/busy/ack/owner got %b/%b/%b/%0d expected 1/0/00/0",
                     ifa.UART_TX, ifa.busy, ifa.ack, ifa.owner);
        end
        rst_a   = 1'b0;
        m_ptr   = 0;
        m_owner = 0;
        // Both requesters pending: pointer back at 0 means requester 0 wins
        q0 = '{8'($urandom_range(0, 255))};
        q1 = '{8'($urandom_range(0, 255))};
        n = 2 * 41 + 2;
        run_scenario(n);
        for (int j = 0; j < n; j++) begin
            n_checks++;
            if ({tr_tx[j], tr_ack[j], tr_busy[j], tr_own[j]} !==
                {ex_tx[j], ex_ack[j], ex_busy[j], ex_own[j]}) begin
                n_errors++;
                $display("FAIL midrst resume cyc %0d: tx/ack/busy/owner got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                         j, tr_tx[j], tr_ack[j], tr_busy[j], tr_own[j],
                         ex_tx[j], ex_ack[j], ex_busy[j], ex_own[j]);
            end
        end
        // Only requester 1 pending
        q0.delete();
        q1 = '{8'($urandom_range(0, 255))};
        n = 41 + 2;
        run_scenario(n);
        n_checks++;
        if (tr_ack[0] !== 2'b10 || tr_tx[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst req1_grant: ack/tx got %b/%b expected 10/0", tr_ack[0], tr_tx[0]);
        end
    endtask

    task automatic test_default_timing();
        int zeros;
        int busy_cnt;
        int first_high;
        ifb.req  = '0;
        ifb.data = '0;
        for (int j = 0; j < 2000; j++) begin
            tick();
            n_checks++;
            if (ifb.UART_TX !== 1'b1 || ifb.ack !== 2'b00) begin
                n_errors++;
                $display("FAIL idle cyc %0d: tx/ack got %b/%b expected 1/00", j, ifb.UART_TX, ifb.ack);
            end
        end
        ifb.req  = 2'b01;
        ifb.data = 16'h00FF;
        zeros      = 0;
        busy_cnt   = 0;
        first_high = -1;
        for (int j = 0; j < 10*DB + 5; j++) begin
            tick();
            if (j == 0) begin
                n_checks++;
                if (ifb.ack !== 2'b01 || ifb.UART_TX !== 1'b0 || ifb.busy !== 1'b1) begin
                    n_errors++;
                    $display("FAIL dflt first_cycle: ack/tx/busy got %b/%b/%b expected 01/0/1",
                             ifb.ack, ifb.UART_TX, ifb.busy);
                end
            end
            if (ifb.ack[0]) ifb.req = 2'b00;
            if (ifb.UART_TX === 1'b0) zeros++;
            else if (first_high < 0) first_high = j;
            if (ifb.busy === 1'b1) busy_cnt++;
        end
        n_checks++;
        if (zeros !== DB || first_high !== DB) begin
            n_errors++;
            $display("FAIL dflt start_bit: low cycles %0d first high at %0d expected %0d and %0d",
                     zeros, first_high, DB, DB);
        end
        n_checks++;
        if (busy_cnt !== 10*DB) begin
            n_errors++;
            $display("FAIL dflt frame_len: busy cycles %0d expected %0d", busy_cnt, 10*DB);
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_random();
        test_reset_mid_frame();
        test_default_timing();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation did not complete within 90000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_uart_tx_arbiter
`default_nettype wire
